// File: rtl/spi_sb_streamer_if.sv
// System-bus port between spi_sb_streamer (initiator) and the hardened SPI IP.
interface spi_sb_streamer_if;
   logic       sb_wr_o;
   logic       sb_stb_o;
   logic [7:0] sb_adr_o;
   logic [7:0] sb_dat_o;
   logic [7:0] sb_dat_i;
   logic       sb_ack_i;

   modport master (
      output sb_wr_o, sb_stb_o, sb_adr_o, sb_dat_o,
      input  sb_dat_i, sb_ack_i
   );

   modport slave (
      input  sb_wr_o, sb_stb_o, sb_adr_o, sb_dat_o,
      output sb_dat_i, sb_ack_i
   );
endinterface

// File: rtl/spi_sb_streamer.sv
// spi_sb_streamer: configures the SPI IP (slave mode) over its system bus,
// then streams result words MSB-first through SPITXDR and drains SPIRXDR.
module spi_sb_streamer #(
   parameter int unsigned WORD_BYTES  = 4,
   parameter logic [7:0]  BASE_ADR    = 8'h00,
   parameter logic [7:0]  CR0_VAL     = 8'h00,
   parameter logic [7:0]  CR1_VAL     = 8'h80,
   parameter logic [7:0]  CR2_VAL     = 8'h00,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic                    sys_clk,
   input  logic                    rst,
   input  logic [8*WORD_BYTES-1:0] word_in,
   input  logic                    word_valid,
   output logic                    word_ready,
   spi_sb_streamer_if.master       sb,
   output logic [7:0]              rx_byte,
   output logic                    rx_valid,
   output logic                    cfg_done,
   output logic                    busy,
   output logic                    bus_err
);

   localparam int unsigned IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [IW-1:0] IDX_MSB  = IW'(WORD_BYTES - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   localparam logic [3:0] OFF_CR0 = 4'h8;
   localparam logic [3:0] OFF_CR1 = 4'h9;
   localparam logic [3:0] OFF_CR2 = 4'hA;
   localparam logic [3:0] OFF_SR  = 4'hC;
   localparam logic [3:0] OFF_TX  = 4'hD;
   localparam logic [3:0] OFF_RX  = 4'hE;

   localparam int unsigned SR_RRDY = 3;
   localparam int unsigned SR_TRDY = 4;

   typedef enum logic [2:0] {
      CFG0, CFG1, CFG2, IDLE, POLL, RDRX, WRTX, ERR
   } state_t;

   state_t                  state_q, state_d;
   logic                    stb_q, stb_d;
   logic                    wr_q, wr_d;
   logic [7:0]              adr_q, adr_d;
   logic [7:0]              dat_q, dat_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [8*WORD_BYTES-1:0] word_q, word_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    busy_q, busy_d;
   logic                    cfg_done_q, cfg_done_d;
   logic                    bus_err_q, bus_err_d;
   logic [7:0]              rx_byte_q, rx_byte_d;
   logic                    rx_valid_q, rx_valid_d;
   logic [3:0]              tmr_q, tmr_d;

   logic                    bus_req;
   logic                    req_wr;
   logic [3:0]              req_off;
   logic [7:0]              req_dat;
   logic                    ack_done;
   logic [7:0]              tx_byte;

   assign word_ready  = cfg_done_q && (state_q == IDLE) && !stb_q;
   assign sb.sb_stb_o = stb_q;
   assign sb.sb_wr_o  = wr_q;
   assign sb.sb_adr_o = adr_q;
   assign sb.sb_dat_o = dat_q;
   assign rx_byte     = rx_byte_q;
   assign rx_valid    = rx_valid_q;
   assign cfg_done    = cfg_done_q;
   assign busy        = busy_q;
   assign bus_err     = bus_err_q;

   // Select the byte addressed by the current index (highest index = MSB).
   always_comb begin
      tx_byte = '0;
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
         if (idx_q == IW'(i)) tx_byte = word_q[8*i +: 8];
      end
   end

   // Next-state, bus-cycle engine and datapath updates.
   always_comb begin
      state_d    = state_q;
      stb_d      = stb_q;
      wr_d       = wr_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      idx_d      = idx_q;
      busy_d     = busy_q;
      cfg_done_d = cfg_done_q;
      bus_err_d  = bus_err_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      tmr_d      = '0;
      bus_req    = 1'b0;
      req_wr     = 1'b0;
      req_off    = OFF_SR;
      req_dat    = '0;

      case (state_q)
         CFG0:    begin bus_req = 1'b1; req_wr = 1'b1; req_off = OFF_CR0; req_dat = CR0_VAL; end
         CFG1:    begin bus_req = 1'b1; req_wr = 1'b1; req_off = OFF_CR1; req_dat = CR1_VAL; end
         CFG2:    begin bus_req = 1'b1; req_wr = 1'b1; req_off = OFF_CR2; req_dat = CR2_VAL; end
         POLL:    begin bus_req = 1'b1; req_off = OFF_SR; end
         RDRX:    begin bus_req = 1'b1; req_off = OFF_RX; end
         WRTX:    begin bus_req = 1'b1; req_wr = 1'b1; req_off = OFF_TX; req_dat = tx_byte; end
         default: ;
      endcase

      ack_done = bus_req && stb_q && sb.sb_ack_i;

      // Every bus state enters with stb low, so stb rises one cycle later;
      // that guarantees the idle gap between back-to-back cycles.
      if (bus_req) begin
         if (!stb_q) begin
            stb_d = 1'b1;
            wr_d  = req_wr;
            adr_d = BASE_ADR | {4'h0, req_off};
            dat_d = req_dat;
            cnt_d = '0;
         end else if (sb.sb_ack_i) begin
            stb_d = 1'b0;
         end else if (cnt_q == CNT_LAST) begin
            stb_d      = 1'b0;
            bus_err_d  = 1'b1;
            busy_d     = 1'b0;
            cfg_done_d = 1'b0;
            state_d    = ERR;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      case (state_q)
         CFG0: if (ack_done) state_d = CFG1;
         CFG1: if (ack_done) state_d = CFG2;
         CFG2: begin
            if (ack_done) begin
               cfg_done_d = 1'b1;
               state_d    = IDLE;
            end
         end
         IDLE: begin
            if (word_valid && word_ready) begin
               word_d  = word_in;
               idx_d   = IDX_MSB;
               busy_d  = 1'b1;
               state_d = POLL;
            end else if (tmr_q == 4'hF) begin
               state_d = POLL;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         POLL: begin
            if (ack_done) begin
               if (sb.sb_dat_i[SR_RRDY])                state_d = RDRX;
               else if (sb.sb_dat_i[SR_TRDY] && busy_q) state_d = WRTX;
               else if (!busy_q)                        state_d = IDLE;
            end
         end
         RDRX: begin
            if (ack_done) begin
               rx_byte_d  = sb.sb_dat_i;
               rx_valid_d = 1'b1;
               state_d    = POLL;
            end
         end
         WRTX: begin
            if (ack_done) begin
               if (idx_q == '0) begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = POLL;
               end
            end
         end
         ERR:     state_d = CFG0;
         default: state_d = CFG0;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= CFG0;
         stb_q      <= 1'b0;
         wr_q       <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         cnt_q      <= '0;
         word_q     <= '0;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         cfg_done_q <= 1'b0;
         bus_err_q  <= 1'b0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         tmr_q      <= '0;
      end else begin
         state_q    <= state_d;
         stb_q      <= stb_d;
         wr_q       <= wr_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         busy_q     <= busy_d;
         cfg_done_q <= cfg_done_d;
         bus_err_q  <= bus_err_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         tmr_q      <= tmr_d;
      end
   end

endmodule

// File: tb/tb_spi_sb_streamer.sv
// Bench for spi_sb_streamer: SPI-IP bus model with scoreboarded transactions.
module tb_spi_sb_streamer;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] word_in = '0;
   logic        word_valid = 1'b0;
   logic        word_ready;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        cfg_done;
   logic        busy;
   logic        bus_err;

   spi_sb_streamer_if bus ();

   spi_sb_streamer #(
      .WORD_BYTES (4),
      .BASE_ADR   (8'h00),
      .CR0_VAL    (8'h00),
      .CR1_VAL    (8'h80),
      .CR2_VAL    (8'h00),
      .ACK_TIMEOUT(64)
   ) dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .word_in   (word_in),
      .word_valid(word_valid),
      .word_ready(word_ready),
      .sb        (bus.master),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .cfg_done  (cfg_done),
      .busy      (busy),
      .bus_err   (bus_err)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic       wr;
      logic [7:0] adr;
      logic [7:0] dat;
   } txn_t;

   typedef struct {
      logic [31:0]     word;
      int              zeros;
      bit              rx;
      logic [3:0][7:0] exp_b;
   } vec_t;

   txn_t       exp_q[$];
   logic [7:0] sr_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] exp_rx[$];

   int         n_chk = 0;
   int         n_pass = 0;
   int         ack_lat = 2;
   logic [7:0] no_ack_adr = 8'hFF;
   bit         to_seen = 1'b0;
   int         to_len = 0;
   int         tx_seen = 0;
   int         sr_left_first = -1;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic push_exp(input logic wr, input logic [7:0] adr, input logic [7:0] dat);
      txn_t e;
      e.wr = wr; e.adr = adr; e.dat = dat;
      exp_q.push_back(e);
   endtask

   task automatic push_cfg();
      push_exp(1'b1, 8'h08, 8'h00);
      push_exp(1'b1, 8'h09, 8'h80);
      push_exp(1'b1, 8'h0A, 8'h00);
   endtask

   // Scoreboard: every transaction except SPISR polls must match the queue head.
   task automatic log_txn(input txn_t t);
      txn_t e;
      if (t.wr || t.adr != 8'h0C) begin
         if (t.wr && t.adr == 8'h0D) begin
            if (tx_seen == 0) sr_left_first = sr_q.size();
            tx_seen++;
         end
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_txn: got wr=%0b adr=%h dat=%h, required no transaction",
                     t.wr, t.adr, t.dat);
         end else begin
            e = exp_q.pop_front();
            check("txn_kind", 32'({t.wr, t.adr}), 32'({e.wr, e.adr}));
            if (e.wr) check("txn_data", 32'(t.dat), 32'(e.dat));
         end
      end
   endtask

   // Bus slave model plus protocol and rx monitors, all sampled on negedge.
   initial begin : bus_model
      int          lat_cnt;
      int          hi_cnt;
      logic        prev_ack;
      logic        prev_stb;
      logic        prev_rxv;
      logic [16:0] prev_req;
      txn_t        t;
      lat_cnt = 0; hi_cnt = 0;
      prev_ack = 1'b0; prev_stb = 1'b0; prev_rxv = 1'b0; prev_req = '0;
      bus.sb_ack_i = 1'b0;
      bus.sb_dat_i = '0;
      forever begin
         @(negedge sys_clk);
         if (prev_rxv) check("rx_pulse_width", 32'(rx_valid), 32'd0);
         else if (rx_valid) begin
            if (exp_rx.size() == 0) begin
               n_chk++;
               $display("FAIL rx_unexpected: got rx_byte=%h, required no strobe", rx_byte);
            end else begin
               check("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
            end
         end
         prev_rxv = rx_valid;
         if (rst) begin
            bus.sb_ack_i = 1'b0;
            lat_cnt = 0; hi_cnt = 0;
            prev_ack = 1'b0; prev_stb = 1'b0;
         end else begin
            if (prev_ack) check("stb_gap", 32'(bus.sb_stb_o), 32'd0);
            else if (prev_stb && bus.sb_stb_o)
               check("req_hold", 32'({bus.sb_wr_o, bus.sb_adr_o, bus.sb_dat_o}), 32'(prev_req));
            if (bus.sb_stb_o) hi_cnt++;
            else begin
               if (hi_cnt > 0 && !prev_ack) begin
                  to_len = hi_cnt;
                  to_seen = 1'b1;
               end
               hi_cnt = 0;
            end
            if (bus.sb_stb_o && !prev_ack) begin
               lat_cnt++;
               if (lat_cnt >= ack_lat && bus.sb_adr_o != no_ack_adr) begin
                  bus.sb_ack_i = 1'b1;
                  t.wr = bus.sb_wr_o; t.adr = bus.sb_adr_o; t.dat = bus.sb_dat_o;
                  if (!t.wr) begin
                     if (t.adr == 8'h0C) begin
                        if (sr_q.size() > 0) bus.sb_dat_i = sr_q.pop_front();
                        else bus.sb_dat_i = 8'h10;
                     end else begin
                        if (rx_q.size() > 0) bus.sb_dat_i = rx_q.pop_front();
                        else bus.sb_dat_i = 8'h00;
                     end
                  end
                  log_txn(t);
               end else begin
                  bus.sb_ack_i = 1'b0;
               end
            end else begin
               bus.sb_ack_i = 1'b0;
               lat_cnt = 0;
            end
            prev_ack = bus.sb_ack_i;
            prev_stb = bus.sb_stb_o;
            prev_req = {bus.sb_wr_o, bus.sb_adr_o, bus.sb_dat_o};
         end
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < 200 && !word_ready; i++) tick();
      check("word_ready_wait", 32'(word_ready), 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w);
      word_in = w;
      word_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      word_valid = 1'b0;
   endtask

   task automatic run_word(input vec_t v);
      tx_seen = 0;
      sr_left_first = -1;
      for (int k = 3; k >= 0; k--) begin
         push_exp(1'b1, 8'h0D, v.exp_b[k]);
         if (v.rx && k == 3) push_exp(1'b0, 8'h0E, 8'h00);
      end
      wait_ready();
      send_word(v.word);
      for (int i = 0; i < v.zeros; i++) sr_q.push_back(8'h00);
      if (v.rx) begin
         sr_q.push_back(8'h10);
         sr_q.push_back(8'h18);
         rx_q.push_back(8'h5A);
         exp_rx.push_back(8'h5A);
      end
      check("busy_set", 32'(busy), 32'd1);
      check("ready_low_busy", 32'(word_ready), 32'd0);
      for (int i = 0; i < 3000 && busy; i++) tick();
      check("busy_fall", 32'(busy), 32'd0);
      check("ready_after", 32'(word_ready), 32'd1);
      check("tx_all_sent", 32'(exp_q.size()), 32'd0);
      if (v.zeros > 0) check("no_tx_before_trdy", 32'(sr_left_first), 32'd0);
      if (v.rx) check("rx_seen", 32'(exp_rx.size()), 32'd0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vecs[0] = '{32'hDEADBEEF, 0,  1'b0, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
      vecs[1] = '{32'h11223344, 0,  1'b1, {8'h11, 8'h22, 8'h33, 8'h44}};
      vecs[2] = '{32'hDEADBEEF, 50, 1'b0, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
      vecs[3] = '{32'h00000000, 0,  1'b0, {8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[4] = '{32'hA5C30F81, 0,  1'b0, {8'hA5, 8'hC3, 8'h0F, 8'h81}};

      // Reset state and configuration sequence.
      rst = 1'b1;
      repeat (3) tick();
      check("reset_outs", 32'({bus.sb_stb_o, bus.sb_wr_o, bus.sb_adr_o, bus.sb_dat_o, rx_byte,
                               rx_valid, word_ready, cfg_done, busy, bus_err}), 32'd0);
      push_cfg();
      rst = 1'b0;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      check("cfg_writes", 32'(exp_q.size()), 32'd0);
      check("cfg_done_early", 32'(cfg_done), 32'd0);
      tick();
      check("cfg_done_rise", 32'(cfg_done), 32'd1);

      // Table-driven word streams.
      for (int v = 0; v < 5; v++) run_word(vecs[v]);

      // Ack timeout on SPICR1, then recovery through CFG0.
      rst = 1'b1;
      tick(); tick();
      exp_q.delete();
      push_exp(1'b1, 8'h08, 8'h00);
      to_seen = 1'b0;
      no_ack_adr = 8'h09;
      rst = 1'b0;
      for (int i = 0; i < 300 && !to_seen; i++) tick();
      check("timeout_seen", 32'(to_seen), 32'd1);
      check("timeout_len", 32'(to_len), 32'd64);
      check("bus_err_set", 32'(bus_err), 32'd1);
      check("cfg_done_clr", 32'(cfg_done), 32'd0);
      no_ack_adr = 8'hFF;
      push_cfg();
      for (int i = 0; i < 300 && !cfg_done; i++) tick();
      check("recfg_done", 32'(cfg_done), 32'd1);
      check("recfg_writes", 32'(exp_q.size()), 32'd0);
      check("bus_err_sticky", 32'(bus_err), 32'd1);

      // Reset while a TXDR write is strobing.
      ack_lat = 8;
      wait_ready();
      send_word(32'hCAFEF00D);
      for (int i = 0; i < 500 && !(bus.sb_stb_o && bus.sb_wr_o && bus.sb_adr_o == 8'h0D); i++) tick();
      check("tx_strobe_seen", 32'({bus.sb_stb_o, bus.sb_wr_o, bus.sb_adr_o}), 32'h30D);
      rst = 1'b1;
      tick();
      check("rst_stb", 32'(bus.sb_stb_o), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      exp_q.delete();
      push_cfg();
      tx_seen = 0;
      ack_lat = 2;
      rst = 1'b0;
      for (int i = 0; i < 300 && !cfg_done; i++) tick();
      check("rst_recfg", 32'(cfg_done), 32'd1);
      repeat (150) tick();
      check("old_word_dropped", 32'(tx_seen), 32'd0);
      check("rst_idle_busy", 32'(busy), 32'd0);
      check("rst_exp_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
